// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style interrupt acknowledge sequencer.
package pic_pkg;
   localparam int IRQ_IDX_W = 3;
   localparam logic [IRQ_IDX_W-1:0] SPURIOUS_IDX = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      ACK1,
      VEC
   } pic_state_e;
endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver: winner of req under rotating priority, its eligibility
// against the in-service bits, and the highest-priority in-service level.
module pic_priority_resolver
   import pic_pkg::*;
(
   input  logic [7:0]           req,
   input  logic [7:0]           isr,
   input  logic [IRQ_IDX_W-1:0] lowest,
   output logic [IRQ_IDX_W-1:0] winner,
   output logic                 eligible,
   output logic [IRQ_IDX_W-1:0] isr_top
);
   logic [IRQ_IDX_W-1:0] lvl;
   logic [IRQ_IDX_W-1:0] win_rank;
   logic [IRQ_IDX_W-1:0] isr_rank;
   logic                 win_found;
   logic                 isr_found;

   always_comb begin
      lvl       = '0;
      winner    = SPURIOUS_IDX;
      isr_top   = '0;
      win_rank  = '0;
      isr_rank  = '0;
      win_found = 1'b0;
      isr_found = 1'b0;
      // Scan from lowest to highest priority so the last hit is the top one; rank 0 is highest.
      for (int i = 7; i >= 0; i--) begin
         lvl = lowest + 3'(i) + 3'd1;
         if (req[lvl]) begin
            winner    = lvl;
            win_rank  = 3'(i);
            win_found = 1'b1;
         end
         if (isr[lvl]) begin
            isr_top   = lvl;
            isr_rank  = 3'(i);
            isr_found = 1'b1;
         end
      end
      eligible = win_found && (!isr_found || (win_rank < isr_rank));
   end
endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259 INTA sequencer: raises int_o one cycle after an eligible request, runs the two-pulse
// acknowledge, handles EOI/AEOI. `PIC_ROTATE_EN` enables automatic rotation on non-specific EOI.
module pic_ack_sequencer
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_IRQ-1:0]   irr,
   input  logic [NUM_IRQ-1:0]   imr,
   input  logic [4:0]           vec_base,
   input  logic                 aeoi,
   input  logic                 inta_n,
   input  logic                 eoi_valid,
   input  logic                 eoi_specific,
   input  logic [IRQ_IDX_W-1:0] eoi_level,
   output logic                 int_o,
   output logic                 ack_clr,
   output logic [IRQ_IDX_W-1:0] ack_idx,
   output logic [NUM_IRQ-1:0]   isr,
   output logic [7:0]           data_o,
   output logic                 data_oe
);
   pic_state_e           state_q, state_d;
   logic                 inta_q;
   logic                 int_q, int_d;
   logic                 ack_clr_q, ack_clr_d;
   logic [IRQ_IDX_W-1:0] ack_idx_q, ack_idx_d;
   logic [NUM_IRQ-1:0]   isr_q, isr_d, isr_set, isr_clr;
   logic [7:0]           data_q, data_d;
   logic                 oe_q, oe_d;
   logic [IRQ_IDX_W-1:0] idx_q, idx_d;
   logic                 spur_q, spur_d;
   logic [IRQ_IDX_W-1:0] lowest, winner, isr_top;
   logic                 eligible;
   logic                 inta_fall, inta_rise;

   assign inta_fall = inta_q & ~inta_n;
   assign inta_rise = ~inta_q & inta_n;

`ifdef PIC_ROTATE_EN
   logic [IRQ_IDX_W-1:0] lowest_q, lowest_d;
   assign lowest = lowest_q;
`else
   assign lowest = 3'd7;
`endif

   pic_priority_resolver u_resolver (
      .req      (irr & ~imr),
      .isr      (isr_q),
      .lowest   (lowest),
      .winner   (winner),
      .eligible (eligible),
      .isr_top  (isr_top)
   );

   always_comb begin
      state_d   = state_q;
      int_d     = int_q;
      ack_clr_d = 1'b0;
      ack_idx_d = ack_idx_q;
      data_d    = data_q;
      oe_d      = oe_q;
      idx_d     = idx_q;
      spur_d    = spur_q;
      isr_set   = '0;
      isr_clr   = '0;
`ifdef PIC_ROTATE_EN
      lowest_d  = lowest_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (eligible) begin
               state_d = ARMED;
               int_d   = 1'b1;
            end
         end
         ARMED: begin
            if (inta_fall) begin
               state_d = ACK1;
               int_d   = 1'b0;
               if (eligible) begin
                  idx_d            = winner;
                  spur_d           = 1'b0;
                  isr_set[winner]  = 1'b1;
                  ack_clr_d        = 1'b1;
                  ack_idx_d        = winner;
               end else begin
                  idx_d  = SPURIOUS_IDX;
                  spur_d = 1'b1;
               end
            end
         end
         ACK1: begin
            if (inta_fall) begin
               state_d = VEC;
               oe_d    = 1'b1;
               data_d  = {vec_base, idx_q};
            end
         end
         VEC: begin
            if (inta_rise) begin
               state_d = IDLE;
               oe_d    = 1'b0;
               if (aeoi && !spur_q) isr_clr[idx_q] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (eoi_valid) begin
         if (eoi_specific) begin
            isr_clr[eoi_level] = 1'b1;
         end else if (|isr_q) begin
            isr_clr[isr_top] = 1'b1;
`ifdef PIC_ROTATE_EN
            lowest_d = isr_top;
`endif
         end
      end
      // An acknowledge set beats any clear of the same bit in this cycle.
      isr_d = (isr_q & ~isr_clr) | isr_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         inta_q    <= 1'b1;
         int_q     <= 1'b0;
         ack_clr_q <= 1'b0;
         ack_idx_q <= '0;
         isr_q     <= '0;
         data_q    <= '0;
         oe_q      <= 1'b0;
         idx_q     <= '0;
         spur_q    <= 1'b0;
`ifdef PIC_ROTATE_EN
         lowest_q  <= 3'd7;
`endif
      end else begin
         state_q   <= state_d;
         inta_q    <= inta_n;
         int_q     <= int_d;
         ack_clr_q <= ack_clr_d;
         ack_idx_q <= ack_idx_d;
         isr_q     <= isr_d;
         data_q    <= data_d;
         oe_q      <= oe_d;
         idx_q     <= idx_d;
         spur_q    <= spur_d;
`ifdef PIC_ROTATE_EN
         lowest_q  <= lowest_d;
`endif
      end
   end

   assign int_o   = int_q;
   assign ack_clr = ack_clr_q;
   assign ack_idx = ack_idx_q;
   assign isr     = isr_q;
   assign data_o  = data_q;
   assign data_oe = oe_q;
endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed self-checking bench for pic_ack_sequencer.
module tb_pic_ack_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irr, imr;
   logic [4:0] vec_base;
   logic       aeoi, inta_n, eoi_valid, eoi_specific;
   logic [2:0] eoi_level;
   logic       int_o, ack_clr, data_oe;
   logic [2:0] ack_idx;
   logic [7:0] isr, data_o;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef PIC_ROTATE_EN
   localparam logic [2:0] ROT_EXP = 3'd2;
`else
   localparam logic [2:0] ROT_EXP = 3'd0;
`endif

   pic_ack_sequencer #(.NUM_IRQ(8)) dut (
      .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .vec_base(vec_base), .aeoi(aeoi),
      .inta_n(inta_n), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
      .int_o(int_o), .ack_clr(ack_clr), .ack_idx(ack_idx), .isr(isr), .data_o(data_o),
      .data_oe(data_oe)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full acknowledge of a single level, acting as the request register (clears irr after ack).
   task automatic do_ack(input logic [2:0] lvl);
      irr = 8'h01 << lvl;
      tick();
      inta_n = 1'b0; tick();
      irr = 8'h00;   tick();
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      inta_n = 1'b1; tick();
   endtask

   task automatic eoi(input logic spec, input logic [2:0] lvl);
      eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl;
      tick();
      eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
   endtask

   task automatic test_reset;
      n_chk++; if (int_o !== 1'b0)    begin n_fail++; $display("FAIL reset_int: got %b exp 0", int_o); end
      n_chk++; if (ack_clr !== 1'b0)  begin n_fail++; $display("FAIL reset_ack_clr: got %b exp 0", ack_clr); end
      n_chk++; if (ack_idx !== 3'd0)  begin n_fail++; $display("FAIL reset_ack_idx: got %0d exp 0", ack_idx); end
      n_chk++; if (isr !== 8'h00)     begin n_fail++; $display("FAIL reset_isr: got %h exp 00", isr); end
      n_chk++; if (data_o !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h exp 00", data_o); end
      n_chk++; if (data_oe !== 1'b0)  begin n_fail++; $display("FAIL reset_oe: got %b exp 0", data_oe); end
   endtask

   task automatic test_basic_ack;
      vec_base = 5'h08;
      irr = 8'h24;
      n_chk++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL basic_int_pre: got %b exp 0", int_o); end
      tick();
      n_chk++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL basic_int_rise: got %b exp 1", int_o); end
      inta_n = 1'b0; tick();
      n_chk++; if (ack_clr !== 1'b1) begin n_fail++; $display("FAIL basic_ack_clr: got %b exp 1", ack_clr); end
      n_chk++; if (ack_idx !== 3'd2) begin n_fail++; $display("FAIL basic_ack_idx: got %0d exp 2", ack_idx); end
      n_chk++; if (isr !== 8'h04)    begin n_fail++; $display("FAIL basic_isr: got %h exp 04", isr); end
      n_chk++; if (int_o !== 1'b0)   begin n_fail++; $display("FAIL basic_int_fall: got %b exp 0", int_o); end
      irr = 8'h21;  // higher-priority arrival after the latch must not change the vector
      tick();
      n_chk++; if (ack_clr !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse: got %b exp 0", ack_clr); end
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      n_chk++; if (data_oe !== 1'b1) begin n_fail++; $display("FAIL basic_oe: got %b exp 1", data_oe); end
      n_chk++; if (data_o !== 8'h42) begin n_fail++; $display("FAIL basic_vec: got %h exp 42", data_o); end
      tick(2);
      n_chk++; if (data_oe !== 1'b1 || data_o !== 8'h42) begin n_fail++; $display("FAIL basic_hold: got oe=%b data=%h exp oe=1 data=42", data_oe, data_o); end
      n_chk++; if (int_o !== 1'b0)   begin n_fail++; $display("FAIL basic_no_reassert: got %b exp 0", int_o); end
      irr = 8'h00;
      inta_n = 1'b1; tick();
      n_chk++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL basic_oe_fall: got %b exp 0", data_oe); end
      tick();
   endtask

   task automatic test_nesting;
      irr = 8'h08; tick(3);
      n_chk++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL nest_blocked: got %b exp 0", int_o); end
      irr = 8'h09; tick();
      n_chk++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL nest_int: got %b exp 1", int_o); end
      inta_n = 1'b0; tick();
      n_chk++; if (isr !== 8'h05)    begin n_fail++; $display("FAIL nest_isr: got %h exp 05", isr); end
      n_chk++; if (ack_idx !== 3'd0) begin n_fail++; $display("FAIL nest_ack_idx: got %0d exp 0", ack_idx); end
      irr = 8'h00;
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      n_chk++; if (data_o !== 8'h40) begin n_fail++; $display("FAIL nest_vec: got %h exp 40", data_o); end
      inta_n = 1'b1; tick();
   endtask

   task automatic test_eoi;
      eoi(1'b1, 3'd0);
      n_chk++; if (isr !== 8'h04) begin n_fail++; $display("FAIL eoi_spec0: got %h exp 04", isr); end
      eoi(1'b1, 3'd2);
      n_chk++; if (isr !== 8'h00) begin n_fail++; $display("FAIL eoi_spec2: got %h exp 00", isr); end
      eoi(1'b0, 3'd0);
      n_chk++; if (isr !== 8'h00) begin n_fail++; $display("FAIL eoi_ns_empty: got %h exp 00", isr); end
      do_ack(3'd3);
      do_ack(3'd1);
      n_chk++; if (isr !== 8'h0A) begin n_fail++; $display("FAIL eoi_setup: got %h exp 0a", isr); end
      eoi(1'b0, 3'd0);
      n_chk++; if (isr !== 8'h08) begin n_fail++; $display("FAIL eoi_nonspec: got %h exp 08", isr); end
      eoi(1'b1, 3'd3);
      n_chk++; if (isr !== 8'h00) begin n_fail++; $display("FAIL eoi_spec3: got %h exp 00", isr); end
      // Specific EOI on the level being acknowledged in the same cycle: set must win.
      irr = 8'h10; tick();
      inta_n = 1'b0; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd4;
      tick();
      eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
      n_chk++; if (isr !== 8'h10 || ack_clr !== 1'b1) begin n_fail++; $display("FAIL eoi_set_wins: got isr=%h ack=%b exp isr=10 ack=1", isr, ack_clr); end
      irr = 8'h00;
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      inta_n = 1'b1; tick();
      eoi(1'b1, 3'd4);
      n_chk++; if (isr !== 8'h00) begin n_fail++; $display("FAIL eoi_spec4: got %h exp 00", isr); end
   endtask

   task automatic test_spurious;
      irr = 8'h10; tick();
      n_chk++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL spur_int: got %b exp 1", int_o); end
      irr = 8'h00; tick();
      n_chk++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL spur_int_held: got %b exp 1", int_o); end
      inta_n = 1'b0; tick();
      n_chk++; if (ack_clr !== 1'b0 || isr !== 8'h00 || int_o !== 1'b0) begin n_fail++; $display("FAIL spur_ack: got ack=%b isr=%h int=%b exp ack=0 isr=00 int=0", ack_clr, isr, int_o); end
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      n_chk++; if (data_o !== 8'h47 || data_oe !== 1'b1) begin n_fail++; $display("FAIL spur_vec: got data=%h oe=%b exp data=47 oe=1", data_o, data_oe); end
      inta_n = 1'b1; tick();
      n_chk++; if (data_oe !== 1'b0 || isr !== 8'h00) begin n_fail++; $display("FAIL spur_end: got oe=%b isr=%h exp oe=0 isr=00", data_oe, isr); end
   endtask

   task automatic test_aeoi;
      aeoi = 1'b1; vec_base = 5'h10;
      irr = 8'h80; tick();
      inta_n = 1'b0; tick();
      n_chk++; if (isr !== 8'h80 || ack_idx !== 3'd7 || ack_clr !== 1'b1) begin n_fail++; $display("FAIL aeoi_ack: got isr=%h idx=%0d ack=%b exp isr=80 idx=7 ack=1", isr, ack_idx, ack_clr); end
      irr = 8'h00;
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      n_chk++; if (data_o !== 8'h87 || isr !== 8'h80) begin n_fail++; $display("FAIL aeoi_vec: got data=%h isr=%h exp data=87 isr=80", data_o, isr); end
      inta_n = 1'b1; tick();
      n_chk++; if (isr !== 8'h00 || data_oe !== 1'b0) begin n_fail++; $display("FAIL aeoi_clear: got isr=%h oe=%b exp isr=00 oe=0", isr, data_oe); end
      aeoi = 1'b0; vec_base = 5'h08;
   endtask

   task automatic test_rotate;
      do_ack(3'd1);
      eoi(1'b0, 3'd0);
      n_chk++; if (isr !== 8'h00) begin n_fail++; $display("FAIL rot_eoi: got %h exp 00", isr); end
      irr = 8'h05; tick();
      inta_n = 1'b0; tick();
      n_chk++; if (ack_idx !== ROT_EXP) begin n_fail++; $display("FAIL rot_winner: got %0d exp %0d", ack_idx, ROT_EXP); end
      irr = 8'h05 & ~(8'h01 << ROT_EXP);
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      n_chk++; if (data_o !== {5'h08, ROT_EXP}) begin n_fail++; $display("FAIL rot_vec: got %h exp %h", data_o, {5'h08, ROT_EXP}); end
      irr = 8'h00;
      inta_n = 1'b1; tick();
      eoi(1'b1, ROT_EXP);
      n_chk++; if (isr !== 8'h00) begin n_fail++; $display("FAIL rot_cleanup: got %h exp 00", isr); end
   endtask

   task automatic test_reset_mid;
      irr = 8'h01; tick();
      inta_n = 1'b0; tick();
      irr = 8'h00;
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      n_chk++; if (data_oe !== 1'b1) begin n_fail++; $display("FAIL rmid_in_vec: got %b exp 1", data_oe); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (data_oe !== 1'b0 || isr !== 8'h00 || int_o !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got oe=%b isr=%h int=%b exp oe=0 isr=00 int=0", data_oe, isr, int_o); end
      n_chk++; if (data_o !== 8'h00 || ack_clr !== 1'b0) begin n_fail++; $display("FAIL rmid_data: got data=%h ack=%b exp data=00 ack=0", data_o, ack_clr); end
      inta_n = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick();
      irr = 8'h01; tick();
      n_chk++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: got %b exp 1", int_o); end
      irr = 8'h00;
   endtask

   initial begin
      rst_n = 1'b0; irr = 8'h00; imr = 8'h00; vec_base = 5'h00; aeoi = 1'b0;
      inta_n = 1'b1; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
      tick(2);
      test_reset();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_basic_ack();
      test_nesting();
      test_eoi();
      test_spurious();
      test_aeoi();
      test_rotate();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
